wb_spi_slave: RTL and testbench

//  Wishbone-mapped SPI target (slave); the responder end of the bus that wb_spi drives as initiator.
//  An external SPI master (or our own wb_spi in loopback) clocks bytes in/out.
//  LM32 firmware reads received bytes and queues reply bytes through 4 registers on a conbus slave port.

---
 rtl/wb_spi_slave_pkg.sv | 21 ++
 rtl/wb_spi_slave_if.sv | 16 +
 rtl/wb_spi_slave_sync_edge.sv | 31 +++
 rtl/wb_spi_slave.sv | 165 ++++++++++++++++
 tb/tb_wb_spi_slave.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_spi_slave_pkg.sv
// Shared constants for the Wishbone SPI target: register offsets and bit positions
// within the STATUS and CTRL registers.
package wb_spi_slave_pkg;

    // Register offsets, decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit indices
    localparam int ST_RXV  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_BUSY = 2;
    localparam int ST_OVR  = 3;

    // CTRL bit indices
    localparam int CT_RXIE  = 0;
    localparam int CT_TXEIE = 1;

endpackage

// File: rtl/wb_spi_slave_if.sv
// Wishbone slave-port bundle for the SPI target (32-bit data, byte addressing).
interface wb_spi_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;

    modport slave  (input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
                    output wb_dat_o, wb_ack_o);
    modport master (output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
                    input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_spi_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle rise/fall
// pulses derived from the synchronised level (one extra flop of history).
module wb_spi_slave_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the raw input through the chain and remember the last synchronised value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone-mapped SPI target, mode 0, MSB first, 8-bit frames. The external SCK is
// oversampled by the system clock; all SPI activity is driven by synchronised edges.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    wb_spi_slave_if.slave      bus,
    output logic               intr,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs_n,
    output logic               spi_miso,
    output logic               spi_miso_oe
);
    logic                   w_sck_rise, w_sck_fall, w_unused_sck_lvl;
    logic                   w_cs_lvl, w_cs_rise, w_cs_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic        r_ack;
    logic [31:0] r_dat_o, w_rdata;
    logic [7:0]  r_rx_data, r_tx_buf, r_tx_shreg;
    logic [6:0]  r_rx_shreg;
    logic [2:0]  r_bit_cnt;
    logic        r_rx_valid, r_overrun, r_tx_full, r_rx_ie, r_txe_ie, r_intr, r_miso_oe;
    logic        w_rx_valid_nxt, w_overrun_nxt, w_tx_full_nxt, w_rx_ie_nxt, w_txe_ie_nxt;
    logic        w_rx_store;

    wb_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .i_async(spi_sck),
        .o_level(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

    wb_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .i_async(spi_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

    // MOSI needs no edge detection, only the same latency as SCK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_mosi_sync <= '0;
        else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end

    wire       w_unused = &{1'b0, bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0],
                            bus.wb_dat_i[31:8]};
    wire [1:0] w_adr    = bus.wb_adr_i[3:2];
    wire       w_req    = bus.wb_stb_i & bus.wb_cyc_i & ~r_ack;
    wire       w_rd_rx  = w_req & ~bus.wb_we_i & (w_adr == REG_RXDATA);
    wire       w_wr_tx  = w_req &  bus.wb_we_i & (w_adr == REG_TXDATA);
    wire       w_wr_st  = w_req &  bus.wb_we_i & (w_adr == REG_STATUS);
    wire       w_wr_ct  = w_req &  bus.wb_we_i & (w_adr == REG_CTRL);

    wire       w_rise_act  = w_sck_rise & ~w_cs_lvl;
    wire       w_fall_act  = w_sck_fall & ~w_cs_lvl;
    wire       w_byte_done = w_rise_act & (r_bit_cnt == 3'd7);
    wire       w_reload    = w_cs_fall | (w_fall_act & (r_bit_cnt == 3'd0));
    wire [7:0] w_rx_byte   = {r_rx_shreg, r_mosi_sync[SYNC_STAGES-1]};

    // Next-state of the flags; a read on the completion cycle frees the slot for the new byte
    always_comb begin
        w_rx_valid_nxt = r_rx_valid;
        w_overrun_nxt  = r_overrun;
        w_tx_full_nxt  = r_tx_full;
        w_rx_store     = 1'b0;
        if (w_rd_rx) w_rx_valid_nxt = 1'b0;
        if (w_wr_st && bus.wb_dat_i[ST_OVR]) w_overrun_nxt = 1'b0;
        if (w_byte_done) begin
            if (!r_rx_valid || w_rd_rx) begin
                w_rx_store     = 1'b1;
                w_rx_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt  = 1'b1;
            end
        end
        // Reload consumes the old buffer; a same-cycle write refills it for the next byte
        if (w_reload) w_tx_full_nxt = 1'b0;
        if (w_wr_tx)  w_tx_full_nxt = 1'b1;
        w_rx_ie_nxt  = w_wr_ct ? bus.wb_dat_i[CT_RXIE]  : r_rx_ie;
        w_txe_ie_nxt = w_wr_ct ? bus.wb_dat_i[CT_TXEIE] : r_txe_ie;
    end

    // Register read mux
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            REG_RXDATA: w_rdata[7:0] = r_rx_data;
            REG_TXDATA: w_rdata[7:0] = r_tx_buf;
            REG_STATUS: begin
                w_rdata[ST_OVR]  = r_overrun;
                w_rdata[ST_BUSY] = ~w_cs_lvl;
                w_rdata[ST_TXE]  = ~r_tx_full;
                w_rdata[ST_RXV]  = r_rx_valid;
            end
            default: begin
                w_rdata[CT_RXIE]  = r_rx_ie;
                w_rdata[CT_TXEIE] = r_txe_ie;
            end
        endcase
    end

    // Single-cycle ack with data captured at the request edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_req ? w_rdata : 32'h0;
        end
    end

    // Register file, flags and the interrupt (tracks the flags' new values)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_tx_buf   <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_full  <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_txe_ie   <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_valid_nxt;
            r_overrun  <= w_overrun_nxt;
            r_tx_full  <= w_tx_full_nxt;
            r_rx_ie    <= w_rx_ie_nxt;
            r_txe_ie   <= w_txe_ie_nxt;
            r_intr     <= (w_rx_ie_nxt & w_rx_valid_nxt) | (w_txe_ie_nxt & ~w_tx_full_nxt);
            if (w_rx_store) r_rx_data <= w_rx_byte;
            if (w_wr_tx)    r_tx_buf  <= bus.wb_dat_i[7:0];
        end
    end

    // SPI shift/count datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_rx_shreg <= '0;
            r_tx_shreg <= '0;
            r_miso_oe  <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_bit_cnt <= '0;
                r_miso_oe <= 1'b1;
            end else if (w_cs_rise) begin
                r_bit_cnt <= '0;
                r_miso_oe <= 1'b0;
            end else if (w_rise_act) begin
                r_rx_shreg <= w_rx_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_reload)        r_tx_shreg <= r_tx_full ? r_tx_buf : DUMMY_BYTE;
            else if (w_fall_act) r_tx_shreg <= {r_tx_shreg[6:0], 1'b0};
        end
    end

    assign bus.wb_ack_o = r_ack;
    assign bus.wb_dat_o = r_dat_o;
    assign intr         = r_intr;
    assign spi_miso_oe  = r_miso_oe;
    assign spi_miso     = r_miso_oe ? r_tx_shreg[7] : 1'b1;
endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: bit-banged SPI master at clk/8 plus Wishbone firmware
// accesses, checked against a byte-level model of the target's registers.
module tb_wb_spi_slave;
    localparam logic [1:0] A_RX = 2'd0, A_TX = 2'd1, A_ST = 2'd2, A_CT = 2'd3;

    logic clk = 1'b0;
    logic reset;
    logic intr, spi_sck, spi_mosi, spi_cs_n, spi_miso, spi_miso_oe;
    wb_spi_slave_if bus();

    wb_spi_slave #(.DUMMY_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus), .intr(intr),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Model state: what firmware would believe the target holds
    logic [7:0] m_rx_data, m_tx_buf, m_first;
    bit         m_rx_valid, m_ovr, m_tx_full, m_rx_ie, m_txe_ie;
    int         m_nbyte;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rx_data = 8'h00; m_tx_buf = 8'h00; m_rx_valid = 0; m_ovr = 0;
        m_tx_full = 0; m_rx_ie = 0; m_txe_ie = 0; m_nbyte = 0; m_first = 8'hFF;
    endtask

    task automatic wb_xfer(input bit we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        int t;
        bus.wb_adr_i = {28'h0, a, 2'b00};
        bus.wb_dat_i = wd;
        bus.wb_we_i  = we;
        bus.wb_sel_i = 4'hF;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        t = 0;
        tick(1);
        while (!bus.wb_ack_o && t < 8) begin
            tick(1);
            t++;
        end
        chk("wb_ack", {31'h0, bus.wb_ack_o}, 32'h1);
        rd = bus.wb_dat_o;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick(1);
    endtask

    task automatic wr_tx(input logic [7:0] d);
        logic [31:0] rd;
        wb_xfer(1, A_TX, {24'hABCDEF, d}, rd);
        m_tx_buf = d; m_tx_full = 1;
    endtask

    task automatic rd_tx();
        logic [31:0] rd;
        wb_xfer(0, A_TX, 32'h0, rd);
        chk("txdata_rd", rd, {24'h0, m_tx_buf});
    endtask

    task automatic wr_ctrl(input logic [1:0] v);
        logic [31:0] rd;
        wb_xfer(1, A_CT, {30'h0, v}, rd);
        m_rx_ie = v[0]; m_txe_ie = v[1];
        wb_xfer(0, A_CT, 32'h0, rd);
        chk("ctrl_rd", rd, {30'h0, m_txe_ie, m_rx_ie});
    endtask

    task automatic rd_rx();
        logic [31:0] rd;
        wb_xfer(0, A_RX, 32'h0, rd);
        chk("rxdata", rd, {24'h0, m_rx_data});
        m_rx_valid = 0;
    endtask

    task automatic rd_status(input bit busy);
        logic [31:0] rd;
        wb_xfer(0, A_ST, 32'h0, rd);
        chk("status", rd, {28'h0, m_ovr, busy, !m_tx_full, m_rx_valid});
    endtask

    task automatic clr_ovr();
        logic [31:0] rd;
        wb_xfer(1, A_ST, 32'h8, rd);
        m_ovr = 0;
    endtask

    task automatic chk_intr(input string tag);
        chk(tag, {31'h0, intr}, {31'h0, (m_rx_ie & m_rx_valid) | (m_txe_ie & !m_tx_full)});
    endtask

    // CS fall: the target picks up a queued reply byte, or will send the dummy byte
    task automatic cs_low();
        spi_cs_n = 1'b0;
        m_first   = m_tx_full ? m_tx_buf : 8'hFF;
        m_tx_full = 0;
        m_nbyte   = 0;
        tick(6);
        chk("miso_oe_on", {31'h0, spi_miso_oe}, 32'h1);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        tick(5);
        chk("miso_idle", {30'h0, spi_miso_oe, spi_miso}, 32'h1);
    endtask

    // One full byte; optionally read RXDATA on the exact cycle the byte lands
    task automatic spi_byte(input logic [7:0] mo, input bit coinc);
        logic [7:0]  got, exp_miso;
        logic [31:0] rd;
        exp_miso = (m_nbyte == 0) ? m_first : 8'hFF;
        for (int b = 7; b >= 0; b--) begin
            spi_mosi = mo[b];
            tick(4);
            got[b]  = spi_miso;
            spi_sck = 1'b1;
            if (b == 0 && coinc) begin
                tick(2);
                wb_xfer(0, A_RX, 32'h0, rd);
                chk("rx_coinc", rd, {24'h0, m_rx_data});
                m_rx_data = mo; m_rx_valid = 1;
            end else if (b == 0) begin
                if (!m_rx_valid) begin m_rx_data = mo; m_rx_valid = 1; end
                else m_ovr = 1;
            end
            tick(4);
            if (b == 0) chk_intr("intr_lat");
            spi_sck = 1'b0;
        end
        tick(4);
        chk("miso_byte", {24'h0, got}, {24'h0, exp_miso});
        m_nbyte++;
    endtask

    task automatic spi_bits(input int n);
        for (int b = 0; b < n; b++) begin
            spi_mosi = $urandom_range(0, 1);
            tick(4);
            spi_sck = 1'b1;
            tick(4);
            spi_sck = 1'b0;
        end
        tick(4);
    endtask

    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 0; bus.wb_sel_i = '0;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
        spi_sck = 0; spi_mosi = 0; spi_cs_n = 1;
        reset = 1'b1;
        model_reset();
        tick(3);
        chk("rst_ack",  {31'h0, bus.wb_ack_o}, 32'h0);
        chk("rst_dat",  bus.wb_dat_o, 32'h0);
        chk("rst_intr", {31'h0, intr}, 32'h0);
        chk("rst_miso", {30'h0, spi_miso_oe, spi_miso}, 32'h1);
        reset = 1'b0;
        tick(2);
        rd_status(0);

        // 1: single byte with a queued reply
        wr_tx(8'hA5);
        rd_tx();
        cs_low();
        spi_byte(8'h3C, 0);
        rd_status(1);
        cs_high();
        rd_status(0);
        rd_rx();

        // 2: two bytes, one reply queued, no read in between -> overrun
        wr_tx(8'h55);
        cs_low();
        spi_byte(8'h11, 0);
        spi_byte(8'h22, 0);
        cs_high();
        rd_status(0);
        rd_rx();
        clr_ovr();
        rd_status(0);

        // 3: aborted partial byte leaves no trace
        cs_low();
        spi_bits(5);
        cs_high();
        rd_status(0);
        cs_low();
        spi_byte(8'h81, 0);
        cs_high();
        rd_rx();

        // 4: receive interrupt rises on arrival and drops on read
        wr_ctrl(2'b01);
        chk_intr("intr_idle");
        cs_low();
        spi_byte(8'h7E, 0);
        cs_high();
        rd_rx();
        chk_intr("intr_clr");

        // 5: RXDATA read coincident with byte completion
        wr_ctrl(2'b00);
        cs_low();
        spi_byte(8'h5A, 0);
        spi_byte(8'h96, 1);
        cs_high();
        rd_status(0);
        rd_rx();

        // 6: reset in the middle of a byte
        wr_ctrl(2'b11);
        cs_low();
        spi_bits(3);
        reset = 1'b1;
        #2;
        chk("mid_rst_miso", {30'h0, spi_miso_oe, spi_miso}, 32'h1);
        chk("mid_rst_intr", {31'h0, intr}, 32'h0);
        chk("mid_rst_ack",  {31'h0, bus.wb_ack_o}, 32'h0);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        tick(3);
        reset = 1'b0;
        model_reset();
        tick(3);
        chk("post_rst_miso", {30'h0, spi_miso_oe, spi_miso}, 32'h1);
        rd_status(0);
        wr_tx(8'hC3);
        cs_low();
        spi_byte(8'h24, 0);
        cs_high();
        rd_rx();

        // Randomised firmware/master interleaving
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: wr_tx(8'($urandom));
                1: wr_ctrl(2'($urandom));
                2: begin
                    int nb;
                    nb = $urandom_range(1, 3);
                    cs_low();
                    for (int k = 0; k < nb; k++) spi_byte(8'($urandom), 0);
                    cs_high();
                end
                3: begin
                    cs_low();
                    spi_bits($urandom_range(1, 7));
                    cs_high();
                end
                4: rd_rx();
                default: begin
                    rd_status(0);
                    if ($urandom_range(0, 1) == 1) clr_ovr();
                end
            endcase
            chk_intr("intr_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
